// File: rtl/secded_dec_pipe.sv
// secded_dec_pipe: two-stage extended-Hamming SECDED decoder with valid/ready
// flow control and saturating corrected/fatal event counters.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   i_valid/o_ready   upstream handshake for i_code
//   i_code            received codeword (bit 0 = overall parity, bit k = position k)
//   o_valid/i_ready   downstream handshake for the decoded result
//   o_data            corrected data (raw extraction when fatal)
//   o_err_corr        single error corrected
//   o_err_detec       any error detected
//   o_err_fatal       uncorrectable error
//   o_err_pos         syndrome (flipped position when corrected)
//   i_clr_cnt         synchronous clear of both counters (wins over increment)
//   o_corr_cnt        saturating count of corrected words delivered
//   o_fatal_cnt       saturating count of fatal words delivered
module secded_dec_pipe #(
    parameter  int unsigned DATA_W = 128,
    parameter  int unsigned CNT_W  = 16,
    // Smallest P with 2**P >= DATA_W+P+1 is either clog2(DATA_W+1) or one more.
    localparam int unsigned LOG_D  = $clog2(DATA_W + 1),
    localparam int unsigned PAR_W  = (((32'd1 << LOG_D) - LOG_D - 1) >= DATA_W) ? LOG_D : LOG_D + 1,
    localparam int unsigned CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CODE_W-1:0] i_code,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_err_corr,
    output logic              o_err_detec,
    output logic              o_err_fatal,
    output logic [PAR_W-1:0]  o_err_pos,
    input  logic              i_clr_cnt,
    output logic [CNT_W-1:0]  o_corr_cnt,
    output logic [CNT_W-1:0]  o_fatal_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              stall;
    logic              out_hs;

    logic [PAR_W-1:0]  syn_c;
    logic              par_c;

    logic              s1_valid;
    logic [PAR_W-1:0]  s1_syn;
    logic              s1_par;
    logic [CODE_W-1:0] s1_code;

    logic              in_range_c;
    logic              corr_c;
    logic              fatal_c;
    logic [CODE_W-1:0] fixed_c;
    logic [DATA_W-1:0] data_c;

    // Whole pipeline freezes while the output is offered but not taken.
    assign stall   = o_valid & ~i_ready;
    assign o_ready = ~stall;
    assign out_hs  = o_valid & i_ready;

    // Syndrome: XOR of the indices of all set positions.
    always_comb begin
        syn_c = '0;
        for (int unsigned k = 1; k < CODE_W; k++) begin
            if (i_code[k]) begin
                syn_c = syn_c ^ PAR_W'(k);
            end
        end
    end

    assign par_c = ^i_code;

    // Stage 1: syndrome, overall parity and raw codeword.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
            s1_code  <= '0;
        end else if (!stall) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_syn  <= syn_c;
                s1_par  <= par_c;
                s1_code <= i_code;
            end
        end
    end

    // Classification, single-bit repair and data extraction.
    always_comb begin
        in_range_c = 32'(s1_syn) < CODE_W;
        corr_c     = s1_par & in_range_c;
        fatal_c    = s1_par ? ~in_range_c : (s1_syn != '0);
        fixed_c    = s1_code;
        data_c     = '0;
        if (corr_c) begin
            for (int unsigned k = 1; k < CODE_W; k++) begin
                if (32'(s1_syn) == k) begin
                    fixed_c[k] = ~s1_code[k];
                end
            end
        end
        // Non-power-of-two positions carry data in ascending order.
        for (int unsigned k = 1, d = 0; k < CODE_W; k++) begin
            if ((k & (k - 1)) != 0) begin
                data_c[d] = fixed_c[k];
                d++;
            end
        end
    end

    // Stage 2: registered outputs, loaded only for valid stage-1 words.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_err_corr  <= 1'b0;
            o_err_detec <= 1'b0;
            o_err_fatal <= 1'b0;
            o_err_pos   <= '0;
        end else if (!stall) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_data      <= data_c;
                o_err_corr  <= corr_c;
                o_err_detec <= corr_c | fatal_c;
                o_err_fatal <= fatal_c;
                o_err_pos   <= s1_syn;
            end
        end
    end

    // Saturating event counters, bumped on output handshake.
    always_ff @(posedge clk) begin
        if (reset || i_clr_cnt) begin
            o_corr_cnt  <= '0;
            o_fatal_cnt <= '0;
        end else if (out_hs) begin
            if (o_err_corr && (o_corr_cnt != CNT_MAX)) begin
                o_corr_cnt <= o_corr_cnt + CNT_W'(1);
            end
            if (o_err_fatal && (o_fatal_cnt != CNT_MAX)) begin
                o_fatal_cnt <= o_fatal_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_secded_dec_pipe.sv
// Directed testbench for secded_dec_pipe (DATA_W=128, CNT_W=2).
module tb_secded_dec_pipe;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned PAR_W  = 8;
    localparam int unsigned CODE_W = 137;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_valid;
    logic              o_ready;
    logic [CODE_W-1:0] i_code;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic              o_err_corr;
    logic              o_err_detec;
    logic              o_err_fatal;
    logic [PAR_W-1:0]  o_err_pos;
    logic              i_clr_cnt;
    logic [CNT_W-1:0]  o_corr_cnt;
    logic [CNT_W-1:0]  o_fatal_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    secded_dec_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_code      (i_code),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_err_corr  (o_err_corr),
        .o_err_detec (o_err_detec),
        .o_err_fatal (o_err_fatal),
        .o_err_pos   (o_err_pos),
        .i_clr_cnt   (i_clr_cnt),
        .o_corr_cnt  (o_corr_cnt),
        .o_fatal_cnt (o_fatal_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One isolated word: present, then check outputs two edges later,
    // optionally pulsing i_clr_cnt in the handshake cycle.
    task automatic run_one(input string tag, input logic [CODE_W-1:0] code,
                           input logic [DATA_W-1:0] exp_data, input logic exp_corr,
                           input logic exp_fatal, input logic [PAR_W-1:0] exp_pos,
                           input logic clr);
        @(negedge clk);
        i_valid = 1'b1;
        i_code  = code;
        @(negedge clk);
        i_valid = 1'b0;
        i_code  = '0;
        @(negedge clk);
        chk({tag, "_valid"}, 128'(o_valid), 128'(1'b1));
        chk({tag, "_data"},  o_data, exp_data);
        chk({tag, "_corr"},  128'(o_err_corr), 128'(exp_corr));
        chk({tag, "_detec"}, 128'(o_err_detec), 128'(exp_corr | exp_fatal));
        chk({tag, "_fatal"}, 128'(o_err_fatal), 128'(exp_fatal));
        chk({tag, "_pos"},   128'(o_err_pos), 128'(exp_pos));
        i_clr_cnt = clr;
        @(negedge clk);
        i_clr_cnt = 1'b0;
    endtask

    logic [CODE_W-1:0] bp_code [4];
    logic [PAR_W-1:0]  bp_pos  [4];
    logic [CODE_W-1:0] oor_code;

    initial begin
        int in_idx;
        int out_idx;
        int stall_cnt;
        logic stalled_once;
        logic [PAR_W-1:0] held_pos;

        reset     = 1'b1;
        i_valid   = 1'b0;
        i_code    = '0;
        i_ready   = 1'b1;
        i_clr_cnt = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst_valid", 128'(o_valid), 128'(1'b0));
        chk("rst_ready", 128'(o_ready), 128'(1'b1));
        chk("rst_data",  o_data, 128'h0);
        chk("rst_flags", 128'({o_err_corr, o_err_detec, o_err_fatal}), 128'h0);
        chk("rst_pos",   128'(o_err_pos), 128'h0);
        chk("rst_ccnt",  128'(o_corr_cnt), 128'h0);
        chk("rst_fcnt",  128'(o_fatal_cnt), 128'h0);

        // Clean words: all-zero, and data[0]=1 (positions 1,2,3 plus parity).
        run_one("clean0", 137'h0, 128'h0, 1'b0, 1'b0, 8'd0, 1'b0);
        run_one("clean1", 137'hF, 128'h1, 1'b0, 1'b0, 8'd0, 1'b0);
        // Single errors.
        run_one("corr12", 137'h1000, 128'h0, 1'b1, 1'b0, 8'd12, 1'b0);
        chk("ccnt_1", 128'(o_corr_cnt), 128'd1);
        chk("fcnt_0", 128'(o_fatal_cnt), 128'd0);
        run_one("corr5d", 137'h2F, 128'h1, 1'b1, 1'b0, 8'd5, 1'b0);
        // Double errors: raw data extracted, pos 18 is data[12].
        run_one("dbl16_18", 137'h50000, 128'h1000, 1'b0, 1'b1, 8'd2, 1'b0);
        chk("fcnt_1", 128'(o_fatal_cnt), 128'd1);
        run_one("dbl1_2", 137'h9, 128'h1, 1'b0, 1'b1, 8'd3, 1'b0);
        // Overall parity bit only, and pos 3 alone.
        run_one("par_only", 137'h1, 128'h0, 1'b1, 1'b0, 8'd0, 1'b0);
        run_one("corr3", 137'h8, 128'h0, 1'b1, 1'b0, 8'd3, 1'b0);
        // Odd weight with syndrome 137 (positions 128,8,1): out of range.
        oor_code = 137'h1_0000_0000_0000_0000_0000_0000_0000_0102;
        run_one("oor", oor_code, 128'h0, 1'b0, 1'b1, 8'd137, 1'b0);
        chk("ccnt_sat", 128'(o_corr_cnt), 128'd3);
        chk("fcnt_sat", 128'(o_fatal_cnt), 128'd3);

        // Standalone clear.
        @(negedge clk);
        i_clr_cnt = 1'b1;
        @(negedge clk);
        i_clr_cnt = 1'b0;
        chk("clr_ccnt", 128'(o_corr_cnt), 128'd0);
        chk("clr_fcnt", 128'(o_fatal_cnt), 128'd0);

        // Backpressure: 4 streamed words, i_ready low 3 cycles after first o_valid.
        for (int i = 0; i < 4; i++) begin
            bp_code[i] = '0;
        end
        bp_code[0][3] = 1'b1; bp_pos[0] = 8'd3;
        bp_code[1][5] = 1'b1; bp_pos[1] = 8'd5;
        bp_code[2][6] = 1'b1; bp_pos[2] = 8'd6;
        bp_code[3][7] = 1'b1; bp_pos[3] = 8'd7;
        in_idx = 0;
        out_idx = 0;
        stall_cnt = 0;
        stalled_once = 1'b0;
        held_pos = '0;
        for (int cyc = 0; cyc < 40 && out_idx < 4; cyc++) begin
            @(negedge clk);
            if (o_valid && !stalled_once) begin
                stalled_once = 1'b1;
                stall_cnt = 3;
                held_pos = o_err_pos;
            end
            i_ready = (stall_cnt == 0);
            i_valid = (in_idx < 4);
            i_code  = (in_idx < 4) ? bp_code[in_idx] : '0;
            #1;
            if (stall_cnt != 0) begin
                chk("bp_oready", 128'(o_ready), 128'(1'b0));
                chk("bp_ovalid", 128'(o_valid), 128'(1'b1));
                chk("bp_hold",   128'(o_err_pos), 128'(held_pos));
                stall_cnt--;
            end
            if (i_valid && o_ready) in_idx++;
            if (o_valid && i_ready) begin
                chk("bp_order", 128'(o_err_pos), 128'(bp_pos[out_idx]));
                out_idx++;
            end
        end
        i_valid = 1'b0;
        i_code  = '0;
        i_ready = 1'b1;
        chk("bp_count", 128'(out_idx), 128'd4);
        repeat (3) @(negedge clk);
        chk("bp_drain", 128'(o_valid), 128'(1'b0));
        chk("bp_ccnt",  128'(o_corr_cnt), 128'd3);

        // Counter saturation and clear priority.
        @(negedge clk);
        i_clr_cnt = 1'b1;
        @(negedge clk);
        i_clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_one("sat", 137'h1000, 128'h0, 1'b1, 1'b0, 8'd12, 1'b0);
        end
        chk("sat_ccnt", 128'(o_corr_cnt), 128'd3);
        run_one("clr6", 137'h1000, 128'h0, 1'b1, 1'b0, 8'd12, 1'b1);
        chk("clr_prio", 128'(o_corr_cnt), 128'd0);
        run_one("inc7", 137'h1000, 128'h0, 1'b1, 1'b0, 8'd12, 1'b0);
        chk("inc_after", 128'(o_corr_cnt), 128'd1);

        // Reset while a word is at the output and another in stage 1.
        @(negedge clk);
        i_valid = 1'b1;
        i_code  = 137'h1000;
        @(negedge clk);
        i_code  = 137'h2F;
        @(negedge clk);
        i_valid = 1'b0;
        i_code  = '0;
        chk("pre_rst_valid", 128'(o_valid), 128'(1'b1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_valid", 128'(o_valid), 128'(1'b0));
        chk("mid_rst_ccnt",  128'(o_corr_cnt), 128'd0);
        chk("mid_rst_data",  o_data, 128'h0);
        chk("mid_rst_pos",   128'(o_err_pos), 128'h0);
        chk("mid_rst_ready", 128'(o_ready), 128'(1'b1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 128'(o_valid), 128'(1'b0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
